// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a data-bus handshake, a misalignment trap,
// a bus-timeout trap and load/store lane formatting.
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_is_word,
  input  logic        i_is_h_or_b,
  input  logic        i_is_unsigned_ld,
  input  logic        i_reg_write_en,
  input  logic [31:0] i_ex_data_out,
  input  logic [31:0] i_reg_out_2,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_valid,
  input  logic        i_trap,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd_addr,
  output logic        o_reg_write_en,
  output logic        o_valid,
  output logic        o_trap
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        w_busy, w_mem_op, w_misal, w_issue, w_timeout;
  logic [1:0]  w_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  assign w_off     = i_ex_data_out[1:0];
  assign w_busy    = r_state == BUSY;
  assign w_mem_op  = i_valid & (i_mem_read | i_mem_write) & ~i_trap;
  assign w_misal   = w_mem_op & (i_is_word ? (w_off != 2'b00) : (i_is_h_or_b & w_off[0]));
  assign w_issue   = w_mem_op & ~w_misal;
  assign w_timeout = w_busy & ~i_dmem_ack & (r_cnt == 8'(MAX_WAIT));
  // Upstream is frozen while BUSY, so the request fields stay stable by construction.
  assign o_dmem_req   = i_rst & (w_busy ? ~w_timeout : w_issue);
  assign o_stall      = i_rst & ~i_dmem_ack & (w_busy ? ~w_timeout : w_issue);
  assign o_dmem_we    = i_mem_write;
  assign o_dmem_addr  = {i_ex_data_out[31:2], 2'b00};
  assign o_dmem_mask  = i_is_word ? 4'b1111 : i_is_h_or_b ? 4'b0011 << w_off : 4'b0001 << w_off;
  assign o_dmem_wdata = i_is_word ? i_reg_out_2 : i_is_h_or_b ? {2{i_reg_out_2[15:0]}} : {4{i_reg_out_2[7:0]}};
  assign w_byte = i_dmem_rdata[{w_off, 3'b000} +: 8];
  assign w_half = i_dmem_rdata[{w_off[1], 4'b0000} +: 16];
  assign w_ld   = i_is_word ? i_dmem_rdata :
                  i_is_h_or_b ? {{16{~i_is_unsigned_ld & w_half[15]}}, w_half} :
                                {{24{~i_is_unsigned_ld & w_byte[7]}}, w_byte};
  assign o_wb_data      = (w_mem_op & i_mem_read) ? w_ld : i_ex_data_out;
  assign o_rd_addr      = i_rd_addr;
  assign o_valid        = i_rst & i_valid & ~o_stall;
  assign o_trap         = o_valid & (i_trap | w_misal | w_timeout);
  assign o_reg_write_en = o_valid & i_reg_write_en & ~o_trap & (i_rd_addr != 5'd0);
  always_comb begin
    w_next     = w_busy ? ((i_dmem_ack | w_timeout) ? IDLE : BUSY) : ((w_issue & ~i_dmem_ack) ? BUSY : IDLE);
    w_cnt_next = w_busy ? ((i_dmem_ack | w_timeout) ? 8'd0 : r_cnt + 8'd1) : ((w_issue & ~i_dmem_ack) ? 8'd1 : 8'd0);
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage; a scoreboard queue holds the expected
// completion of each instruction and a monitor checks it when o_valid fires.
module tb_mem_stage;
  localparam int MW = 4;
  logic        i_clk = 0, i_rst = 0;
  logic        i_mem_read = 0, i_mem_write = 0, i_is_word = 0, i_is_h_or_b = 0, i_is_unsigned_ld = 0;
  logic        i_reg_write_en = 0, i_valid = 0, i_trap = 0, i_dmem_ack = 0;
  logic [31:0] i_ex_data_out = 0, i_reg_out_2 = 0, i_dmem_rdata = 0;
  logic [4:0]  i_rd_addr = 0;
  logic        o_dmem_req, o_dmem_we, o_stall, o_reg_write_en, o_valid, o_trap;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
  logic [3:0]  o_dmem_mask;
  logic [4:0]  o_rd_addr;

  mem_stage #(.MAX_WAIT(MW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_is_word(i_is_word), .i_is_h_or_b(i_is_h_or_b), .i_is_unsigned_ld(i_is_unsigned_ld),
    .i_reg_write_en(i_reg_write_en), .i_ex_data_out(i_ex_data_out), .i_reg_out_2(i_reg_out_2),
    .i_rd_addr(i_rd_addr), .i_valid(i_valid), .i_trap(i_trap), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_mask(o_dmem_mask), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_wb_data(o_wb_data), .o_rd_addr(o_rd_addr),
    .o_reg_write_en(o_reg_write_en), .o_valid(o_valid), .o_trap(o_trap));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] wb;
    logic        trap;
    logic        we;
    logic [4:0]  rd;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) if (o_valid) begin
    if (q.size() == 0) chk("unexpected_completion", 32'(o_valid), 32'd0);
    else begin
      exp_t e;
      e = q.pop_front();
      chk("trap", 32'(o_trap), 32'(e.trap));
      chk("reg_we", 32'(o_reg_write_en), 32'(e.we));
      chk("rd_addr", 32'(o_rd_addr), 32'(e.rd));
      if (!e.trap) chk("wb_data", o_wb_data, e.wb);
    end
  end

  task automatic op(input logic rd_, wr_, word, hb, uns, rwe, trp,
                    input logic [31:0] addr, data, rdata, input logic [4:0] rd,
                    input int ack_cyc, done, input logic [31:0] exp_wb,
                    input logic exp_trap, exp_we, exp_req,
                    input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
    exp_t e;
    e.wb = exp_wb; e.trap = exp_trap; e.we = exp_we; e.rd = rd;
    q.push_back(e);
    @(posedge i_clk); #1;
    i_valid = 1; i_mem_read = rd_; i_mem_write = wr_; i_is_word = word; i_is_h_or_b = hb;
    i_is_unsigned_ld = uns; i_reg_write_en = rwe; i_trap = trp; i_ex_data_out = addr;
    i_reg_out_2 = data; i_dmem_rdata = rdata; i_rd_addr = rd;
    for (int c = 0; c <= 20; c++) begin
      i_dmem_ack = (c == ack_cyc);
      @(negedge i_clk);
      if (c == 0) begin
        chk("req", 32'(o_dmem_req), 32'(exp_req));
        if (wr_ && exp_req) begin
          chk("we", 32'(o_dmem_we), 32'd1);
          chk("addr", o_dmem_addr, {addr[31:2], 2'b00});
          chk("mask", 32'(o_dmem_mask), 32'(exp_mask));
          chk("wdata", o_dmem_wdata, exp_wdata);
        end
      end
      if (done > 0 && exp_trap && c == done) chk("req_at_timeout", 32'(o_dmem_req), 32'd0);
      chk("stall", 32'(o_stall), 32'(c < done));
      if (!o_stall) break;
      if (c == 20) chk("completion_bound", 32'(o_stall), 32'd0);
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    i_valid = 0; i_mem_read = 0; i_mem_write = 0; i_trap = 0; i_dmem_ack = 0;
  endtask

  initial begin
    i_valid = 1; i_mem_read = 1; i_dmem_ack = 1; i_reg_write_en = 1; i_rd_addr = 5'd3;
    #12;
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_trap", 32'(o_trap), 32'd0);
    chk("rst_we", 32'(o_reg_write_en), 32'd0);
    i_valid = 0; i_mem_read = 0; i_dmem_ack = 0; i_reg_write_en = 0;
    #10 i_rst = 1;
    //  rd wr wd hb un rwe trp addr          data          rdata         rd  ack done exp_wb        trp we req mask     wdata
    op(1, 0, 0, 0, 0, 1, 0, 32'h0000_1003, 32'h0,        32'h8011_2233, 5, 0,  0, 32'hFFFF_FF80, 0, 1, 1, 4'b0000, 32'h0);
    op(0, 1, 0, 1, 0, 0, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        6, 3,  3, 32'h0000_2002, 0, 0, 1, 4'b1100, 32'hABCD_ABCD);
    op(1, 0, 1, 0, 0, 1, 0, 32'h0000_3001, 32'h0,        32'h0,        7, 0,  0, 32'h0,        1, 0, 0, 4'b0000, 32'h0);
    op(1, 0, 1, 0, 0, 1, 0, 32'h0000_4000, 32'h0,        32'h0,        8, -1, 4, 32'h0,        1, 0, 1, 4'b0000, 32'h0);
    op(1, 0, 1, 0, 0, 1, 0, 32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 8, 4,  4, 32'hDEAD_BEEF, 0, 1, 1, 4'b0000, 32'h0);
    op(0, 0, 0, 0, 0, 1, 0, 32'h1234_5677, 32'h0,        32'h0,        9, -1, 0, 32'h1234_5677, 0, 1, 0, 4'b0000, 32'h0);
    op(1, 0, 0, 1, 1, 1, 0, 32'h0000_5002, 32'h0,        32'h8001_7FFF, 10, 1, 1, 32'h0000_8001, 0, 1, 1, 4'b0000, 32'h0);
    op(1, 0, 0, 1, 0, 1, 0, 32'h0000_5000, 32'h0,        32'h1234_8001, 11, 0, 0, 32'hFFFF_8001, 0, 1, 1, 4'b0000, 32'h0);
    op(0, 1, 0, 0, 0, 0, 0, 32'h0000_6001, 32'h0000_00A5, 32'h0,        12, 0, 0, 32'h0000_6001, 0, 0, 1, 4'b0010, 32'hA5A5_A5A5);
    op(1, 0, 1, 0, 0, 1, 0, 32'h0000_6004, 32'h0,        32'h5555_AAAA, 0,  2, 2, 32'h5555_AAAA, 0, 0, 1, 4'b0000, 32'h0);
    op(1, 0, 1, 0, 0, 1, 1, 32'h0000_6008, 32'h0,        32'h0,        13, 0, 0, 32'h0,        1, 0, 0, 4'b0000, 32'h0);
    op(0, 1, 1, 0, 0, 0, 0, 32'h0000_700C, 32'hCAFE_F00D, 32'h0,        14, 1, 1, 32'h0000_700C, 0, 0, 1, 4'b1111, 32'hCAFE_F00D);
    op(0, 1, 0, 1, 0, 0, 0, 32'h0000_7001, 32'h0000_1234, 32'h0,        15, 0, 0, 32'h0,        1, 0, 0, 4'b0000, 32'h0);
    op(1, 0, 0, 0, 1, 1, 0, 32'h0000_1001, 32'h0,        32'h8011_2233, 16, 0, 0, 32'h0000_0022, 0, 1, 1, 4'b0000, 32'h0);
    // Reset in the middle of a stalled load: the request is abandoned.
    @(posedge i_clk); #1;
    i_valid = 1; i_mem_read = 1; i_is_word = 1; i_ex_data_out = 32'h0000_8000; i_rd_addr = 5'd17;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("busy_req", 32'(o_dmem_req), 32'd1);
    chk("busy_stall", 32'(o_stall), 32'd1);
    #2 i_rst = 0;
    #1;
    chk("async_rst_req", 32'(o_dmem_req), 32'd0);
    chk("async_rst_stall", 32'(o_stall), 32'd0);
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk); #1;
    i_valid = 0; i_mem_read = 0;
    @(posedge i_clk); #1 i_rst = 1;
    op(1, 0, 1, 0, 0, 1, 0, 32'h0000_8000, 32'h0,        32'h0BAD_F00D, 17, 0, 0, 32'h0BAD_F00D, 0, 1, 1, 4'b0000, 32'h0);
    repeat (2) @(posedge i_clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning: cycles waited in BUSY without i_dmem_ack before a bus-timeout trap (range 1-255).
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-low; ports are named i_clk and i_rst.
REQ-003 SHALL have ports, one per line (name  direction  width  meaning):
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-low reset
- i_mem_read, i_mem_write  in  1  load / store in this stage
- i_is_word, i_is_h_or_b, i_is_unsigned_ld  in  1  size select (word; else halfword if h_or_b=1, byte if 0); zero-extend load
- i_reg_write_en  in  1  instruction writes rd
- i_ex_data_out  in  32  effective address, or ALU result for non-memory ops
- i_reg_out_2  in  32  store data
- i_rd_addr  in  5  destination register
- i_valid, i_trap  in  1  instruction valid; upstream trap
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  32  word address {i_ex_data_out[31:2],2'b00}
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_mask  out  4  byte enables
- i_dmem_ack  in  1  request accepted/completed; read data valid this cycle
- i_dmem_rdata  in  32  read data
- o_stall  out  1  freeze EX/MEM and upstream
- o_wb_data  out  32  writeback value
- o_rd_addr  out  5  = i_rd_addr
- o_reg_write_en  out  1  qualified write enable
- o_valid  out  1  instruction completes this cycle
- o_trap  out  1  trap completes this cycle

Function
REQ-004 SHALL implement FSM states IDLE and BUSY plus an 8-bit wait counter.
REQ-005 mem_op = i_valid & (i_mem_read | i_mem_write) & ~i_trap.
REQ-006 Misaligned: word with addr[1:0]!=0, or halfword with addr[0]=1; misaligned mem_op SHALL issue no request, SHALL complete immediately with o_trap=1, and SHALL suppress o_reg_write_en.
REQ-007 IDLE, aligned mem_op: o_dmem_req=1 combinationally; ack same cycle -> complete, stay IDLE, o_stall=0 (zero-wait); else -> BUSY, o_stall=1, counter=1.
REQ-008 BUSY: o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_mask SHALL stay asserted/stable; o_stall=1 until the completion cycle.
REQ-009 BUSY with i_dmem_ack: complete; o_stall=0 that cycle; next state IDLE; counter=0.
REQ-010 BUSY without ack and counter==MAX_WAIT: complete with o_trap=1, reg write suppressed, o_dmem_req=0 that cycle, -> IDLE; else counter+1.
REQ-011 Ack arriving the same cycle as timeout SHALL win (normal completion).
REQ-012 Requests are non-cancellable; no new request SHALL issue while BUSY; inputs are held by o_stall.
REQ-013 Store mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-014 Load: select byte rdata[8*a+:8] or half rdata[16*a[1]+:16], sign-extend unless i_is_unsigned_ld; word passes through.
REQ-015 o_wb_data = extracted load data on load completion; else i_ex_data_out.
REQ-016 o_valid = i_valid & ~o_stall; o_trap = o_valid & (i_trap | misaligned | timeout); o_reg_write_en = o_valid & i_reg_write_en & ~o_trap & (rd!=0).
REQ-017 Non-memory valid instructions SHALL complete in the same cycle (0 latency).

Reset
REQ-018 While i_rst=0: state IDLE, counter 0, o_dmem_req=0, o_stall=0, o_valid=0, o_trap=0, o_reg_write_en=0, regardless of inputs.
REQ-019 Reset asserted in BUSY SHALL drop o_dmem_req asynchronously; the operation is abandoned.

Verification
REQ-020 Load byte addr 0x1003, rdata 0x80112233, signed, ack on cycle 0 -> o_wb_data 0xFFFFFF80, o_stall 0, o_valid 1.
REQ-021 Store half addr 0x2002, data 0x0000ABCD, ack on cycle 3 -> mask 4'b1100, wdata 0xABCDABCD, o_stall 1 for cycles 0-2, completion on cycle 3.
REQ-022 Load word addr 0x3001 -> o_dmem_req 0, o_trap 1, o_reg_write_en 0, no stall.
REQ-023 MAX_WAIT=4, no ack -> o_stall 1 for 4 cycles, o_trap 1 on the 5th cycle, then IDLE; repeat with ack on the 5th cycle -> normal completion, no trap.
REQ-024 i_rst low mid-BUSY -> o_dmem_req and o_stall 0 immediately; after release the next load issues normally.
